vga_image_scanout: RTL and testbench
====================================

Name: vga_image_scanout

Overview:
- Downstream consumer of the decrypter's output frame buffer.
- Generates 640x480@60 Hz VGA timing from the 25 MHz pixel clock.
- Reads the decrypted 175x175 8-bit image from the synchronous-read BRAM port and places it at a fixed window on screen.
- Pixels outside the window, or shown before the decrypter reports done, are black.

Parameters:
- IMG_W, 175, image width in pixels
- IMG_H, 175, image height in pixels
- X0, 232, first visible column of the image window
- Y0, 152, first visible line of the image window
- ADDR_W, 15, frame-buffer address width

Ports:
- clk  in  1  25 MHz pixel clock
- rst_n  in  1  asynchronous, active-low reset
- frame_ready  in  1  decrypter done flag; level, may assert at any time
- mem_data  in  8  BRAM read data; valid one clock after read_addr is sampled
- read_addr  out  ADDR_W  BRAM read address (registered)
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- red  out  3  pixel red = mem_data[7:5]
- green  out  3  pixel green = mem_data[4:2]
- blue  out  2  pixel blue = mem_data[1:0]
- armed  out  1  high while the image is being displayed

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: h_cnt=0, v_cnt=0, read_addr=0, hsync=1, vsync=1, red/green/blue=0, armed=0, all pipeline stages cleared.
- Horizontal counter h_cnt counts 0..799 and wraps to 0.
  - Visible columns: 0..639. Front porch: 640..655. Sync: 656..751. Back porch: 752..799.
- Vertical counter v_cnt advances when h_cnt wraps and counts 0..524.
  - Visible lines: 0..479. Front porch: 480..489. Sync: 490..491. Back porch: 492..524.
- Window: in_win is true when X0 <= h_cnt < X0+IMG_W and Y0 <= v_cnt < Y0+IMG_H.
- Address generation (incremental; no multiplier):
  - addr_cnt resets to 0 whenever h_cnt=0 and v_cnt=0.
  - addr_cnt increments by 1 on each cycle where in_win is true.
  - read_addr = addr_cnt during each in-window cycle, so pixel (c,r) of the image is read at address r*IMG_W+c.
  - First window pixel reads address 0; last reads 30624.
  - Outside the window, read_addr holds its last value.
  - Over one frame the address counter never exceeds IMG_W*IMG_H-1.
- Arming:
  - A sticky flag pend is set on any cycle where frame_ready=1.
  - armed is set from pend only at the frame boundary (h_cnt=799, v_cnt=524), so no partial or torn frame is ever shown.
  - armed stays high until reset, even if frame_ready deasserts.
- Pipeline (two stages; sync and data stay aligned):
  - Cycle n: counters at (h,v); read_addr presented.
  - Cycle n+1: mem_data valid; the delayed in_win and armed values are available.
  - Cycle n+2: registered outputs visible.
- Output rules:
  - hsync/vsync are computed from cycle-n counters and delayed two cycles, so the total output latency is exactly 2 clocks for both syncs and RGB.
  - RGB = mem_data split as above when delayed (in_win & armed) is true; otherwise 0.
  - RGB is forced to 0 outside the visible area.
- Reset mid-frame: all state returns to reset values immediately and armed clears. The next frame starts from (0,0) after rst_n releases, and the image is only redisplayed after frame_ready is seen again plus a frame boundary.

Optional Feature:
- Macro: PIXEL_DOUBLE_EN.
- When defined:
  - Each image pixel is drawn as a 2x2 block; the window becomes 2*IMG_W by 2*IMG_H.
  - Default X0/Y0 are recomputed as 145/65.
  - addr_cnt increments only on every second in-window column.
  - At the start of each window line, addr_cnt is saved as row_base. On the second line of each pair, addr_cnt is reloaded from row_base, so each image row is read twice.
  - Addresses stay within 0..30624.
- When undefined: 1:1 mapping as described in Behaviour; no row_base register exists.

Test Plan:
- Reset then free-run: hsync low for exactly 96 clocks per 800-clock line, first falling edge 2 clocks after h_cnt=656. vsync low for 2 lines per 525-line frame. RGB=0 throughout while frame_ready=0.
- frame_ready pulsed high for 1 cycle mid-frame (v_cnt=300) -> armed rises at the next frame boundary only; the current frame remains black and the next frame shows the image.
- Armed, BRAM model returns mem_data=addr[7:0]:
  - read_addr=0 at (232,152), read_addr=174 at (406,152), read_addr=175 at (232,153), read_addr=30624 at (406,326).
  - RGB at screen position equals the model data 2 clocks later.
- Armed, mem_data forced to 8'hE0 -> inside window red=7, green=0, blue=0; at column 231 and column 407, RGB=0.
- rst_n dropped at v_cnt=200 while armed -> outputs immediately return to reset values and armed=0. The image does not return until a new frame_ready followed by a frame boundary.
- With PIXEL_DOUBLE_EN: address sequence per window line is 0,0,1,1,...,174,174. Lines 65 and 66 read identical addresses, and line 67 starts at 175.

Source files
------------

// File: rtl/vga_image_scanout.sv
// vga_image_scanout: 640x480@60 VGA timing with a frame-buffer image window.
// Optional PIXEL_DOUBLE_EN draws every image pixel as a 2x2 block.
module vga_image_scanout #(
  parameter int IMG_W  = 175,
  parameter int IMG_H  = 175,
`ifdef PIXEL_DOUBLE_EN
  parameter int X0     = 145,
  parameter int Y0     = 65,
`else
  parameter int X0     = 232,
  parameter int Y0     = 152,
`endif
  parameter int ADDR_W = 15,
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_ready,
  input  logic [7:0]        mem_data,
  output logic [ADDR_W-1:0] read_addr,
  output logic              hsync,
  output logic              vsync,
  output logic [2:0]        red,
  output logic [2:0]        green,
  output logic [1:0]        blue,
  output logic              armed
);

`ifdef PIXEL_DOUBLE_EN
  localparam int SC = 2;
`else
  localparam int SC = 1;
`endif

  localparam logic [9:0] H_LAST = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VE   = 10'(H_VIS);
  localparam logic [9:0] V_VE   = 10'(V_VIS);
  localparam logic [9:0] HS0    = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS1    = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VS0    = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS1    = 10'(V_VIS + V_FP + V_SYNC);
  localparam logic [9:0] WX0    = 10'(X0);
  localparam logic [9:0] WX1    = 10'(X0 + SC * IMG_W);
  localparam logic [9:0] WY0    = 10'(Y0);
  localparam logic [9:0] WY1    = 10'(Y0 + SC * IMG_H);

  logic [9:0]        h_q, h_d, v_q, v_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              first_q, first_d;
  logic              pend_q, pend_d;
  logic              armed_q, armed_d;
  logic              hs1_q, vs1_q, sh1_q;
  logic              hs2_q, vs2_q;
  logic [7:0]        rgb_q, rgb_d;
  logic              h_wrap, v_wrap;
  logic              win_c, win_n;
  logic              hs_c, vs_c, vis_c;
`ifdef PIXEL_DOUBLE_EN
  logic [ADDR_W-1:0] base_q, base_d;
`endif

  function automatic logic in_win(input logic [9:0] h, input logic [9:0] v);
    return (h >= WX0) && (h < WX1) && (v >= WY0) && (v < WY1);
  endfunction

  always_comb begin
    h_wrap = (h_q == H_LAST);
    v_wrap = (v_q == V_LAST);
    h_d    = h_wrap ? 10'd0 : h_q + 10'd1;
    v_d    = v_q;
    if (h_wrap) v_d = v_wrap ? 10'd0 : v_q + 10'd1;
    win_c  = in_win(h_q, v_q);
    win_n  = in_win(h_d, v_d);
    hs_c   = !((h_q >= HS0) && (h_q < HS1));
    vs_c   = !((v_q >= VS0) && (v_q < VS1));
    vis_c  = (h_q < H_VE) && (v_q < V_VE);
  end

  // Address is prepared for the next cycle so it lines up with the counters.
  always_comb begin
    addr_d  = addr_q;
    first_d = first_q;
`ifdef PIXEL_DOUBLE_EN
    base_d  = base_q;
`endif
    if (h_d == 10'd0 && v_d == 10'd0) begin
      first_d = 1'b1;
    end else if (win_n) begin
      first_d = 1'b0;
      addr_d  = first_q ? '0 : addr_q + ADDR_W'(1);
`ifdef PIXEL_DOUBLE_EN
      if (h_d == WX0) begin
        if (v_d[0] ^ WY0[0]) addr_d = base_q;
        else                 base_d = addr_d;
      end else if (h_d[0] ^ WX0[0]) begin
        addr_d = addr_q;
      end
`endif
    end
  end

  always_comb begin
    pend_d  = pend_q | frame_ready;
    armed_d = armed_q | (h_wrap & v_wrap & pend_q);
    rgb_d   = sh1_q ? mem_data : 8'h00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q     <= '0;
      v_q     <= '0;
      addr_q  <= '0;
      first_q <= 1'b1;
      pend_q  <= 1'b0;
      armed_q <= 1'b0;
      hs1_q   <= 1'b1;
      vs1_q   <= 1'b1;
      sh1_q   <= 1'b0;
      hs2_q   <= 1'b1;
      vs2_q   <= 1'b1;
      rgb_q   <= '0;
`ifdef PIXEL_DOUBLE_EN
      base_q  <= '0;
`endif
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      addr_q  <= addr_d;
      first_q <= first_d;
      pend_q  <= pend_d;
      armed_q <= armed_d;
      hs1_q   <= hs_c;
      vs1_q   <= vs_c;
      sh1_q   <= win_c & armed_q & vis_c;
      hs2_q   <= hs1_q;
      vs2_q   <= vs1_q;
      rgb_q   <= rgb_d;
`ifdef PIXEL_DOUBLE_EN
      base_q  <= base_d;
`endif
    end
  end

  assign read_addr = addr_q;
  assign hsync     = hs2_q;
  assign vsync     = vs2_q;
  assign red       = rgb_q[7:5];
  assign green     = rgb_q[4:2];
  assign blue      = rgb_q[1:0];
  assign armed     = armed_q;

endmodule

// File: tb/tb_vga_image_scanout.sv
// tb_vga_image_scanout: scoreboard bench with a screen-position reference
// model, run on a reduced raster so several frames fit in a short run.
module tb_vga_image_scanout;

  localparam int IMG_W  = 12;
  localparam int IMG_H  = 9;
  localparam int X0     = 30;
  localparam int Y0     = 10;
  localparam int ADDR_W = 7;
  localparam int H_VIS  = 80;
  localparam int H_FP   = 8;
  localparam int H_SYNC = 12;
  localparam int H_BP   = 10;
  localparam int V_VIS  = 40;
  localparam int V_FP   = 3;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 5;
  localparam int HT     = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int VT     = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int FR     = HT * VT;

  typedef struct {
    logic       hs;
    logic       vs;
    logic [7:0] rgb;
  } vid_t;

  typedef struct {
    int   addr;
    logic arm;
  } now_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              frame_ready;
  logic [7:0]        mem_data;
  logic [ADDR_W-1:0] read_addr;
  logic              hsync, vsync, armed;
  logic [2:0]        red, green;
  logic [1:0]        blue;

  logic [7:0] img [0:127];

  vid_t exp_q[$];
  now_t now_q[$];

  int   checks = 0;
  int   errors = 0;
  int   p;
  int   last;
  bit   seen;
  bit   arm_m;
  bit   running = 0;

  vga_image_scanout #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .X0(X0), .Y0(Y0), .ADDR_W(ADDR_W),
    .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_ready(frame_ready),
    .mem_data   (mem_data),
    .read_addr  (read_addr),
    .hsync      (hsync),
    .vsync      (vsync),
    .red        (red),
    .green      (green),
    .blue       (blue),
    .armed      (armed)
  );

  always #20 clk = ~clk;

  // Synchronous-read frame buffer.
  always @(posedge clk) mem_data <= img[read_addr];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s pos=%0d actual=%0d required=%0d", name, p, act, req);
    end
  endtask

  task automatic fill(input bit solid);
    for (int i = 0; i < 128; i++) img[i] = solid ? 8'hE0 : 8'($urandom);
  endtask

  // Reference: expected behaviour at raster position p, from screen geometry.
  task automatic cycle(input logic fr);
    int   h, v;
    bit   inw;
    vid_t e;
    now_t n;
    frame_ready = fr;
    h = p % HT;
    v = (p / HT) % VT;
    if (h == 0 && v == 0 && p > 0 && seen) arm_m = 1;
    inw = (h >= X0) && (h < X0 + IMG_W) && (v >= Y0) && (v < Y0 + IMG_H);
    if (inw) last = (v - Y0) * IMG_W + (h - X0);
    n.addr = last;
    n.arm  = arm_m;
    now_q.push_back(n);
    e.hs  = !((h >= H_VIS + H_FP) && (h < H_VIS + H_FP + H_SYNC));
    e.vs  = !((v >= V_VIS + V_FP) && (v < V_VIS + V_FP + V_SYNC));
    e.rgb = (arm_m && inw) ? img[last] : 8'h00;
    exp_q.push_back(e);
    if (fr) seen = 1;
    @(negedge clk);
    p++;
  endtask

  task automatic run_to(input int target, input int a, input int b);
    while (p < target) cycle(p >= a && p <= b);
  endtask

  task automatic release_rst();
    vid_t r;
    r.hs  = 1'b1;
    r.vs  = 1'b1;
    r.rgb = 8'h00;
    rst_n = 1'b1;
    p     = 0;
    last  = 0;
    seen  = 0;
    arm_m = 0;
    exp_q.delete();
    now_q.delete();
    exp_q.push_back(r);
    exp_q.push_back(r);
    running = 1;
  endtask

  task automatic chk_reset(input string tag);
    #1;
    chk({tag, "_hsync"}, int'(hsync), 1);
    chk({tag, "_vsync"}, int'(vsync), 1);
    chk({tag, "_rgb"}, int'({red, green, blue}), 0);
    chk({tag, "_armed"}, int'(armed), 0);
    chk({tag, "_addr"}, int'(read_addr), 0);
  endtask

  initial begin : monitor
    vid_t e;
    now_t n;
    forever begin
      @(negedge clk);
      #1;
      if (running) begin
        if (exp_q.size() < 3 || now_q.size() < 1) begin
          checks++;
          errors++;
          $display("FAIL queue_underflow pos=%0d actual=%0d required=3",
                   p, exp_q.size());
        end else begin
          e = exp_q.pop_front();
          n = now_q.pop_front();
          chk("hsync", int'(hsync), int'(e.hs));
          chk("vsync", int'(vsync), int'(e.vs));
          chk("rgb", int'({red, green, blue}), int'(e.rgb));
          chk("read_addr", int'(read_addr), n.addr);
          chk("armed", int'(armed), int'(n.arm));
        end
      end
    end
  end

  initial begin : stim
    int a, len;
    rst_n       = 1'b0;
    frame_ready = 1'b0;
    p           = 0;
    fill(0);
    repeat (3) @(negedge clk);
    chk_reset("reset");
    @(negedge clk);
    release_rst();
    // Frame 0 stays black; the pulse arms the following frame.
    run_to(FR, 30 * HT + 50, 30 * HT + 50);
    run_to(FR + 45 * HT, -1, -1);
    fill(1);
    a = 2 * FR + $urandom_range(100, FR - 300);
    len = $urandom_range(0, 60);
    run_to(2 * FR + 45 * HT, a, a + len);
    fill(0);
    run_to(3 * FR + 14 * HT + 35, a, a + len);
    running = 0;
    rst_n = 1'b0;
    chk_reset("midreset");
    repeat (2) @(negedge clk);
    release_rst();
    a = FR + $urandom_range(100, FR - 300);
    len = $urandom_range(0, 80);
    run_to(3 * FR + 100, a, a + len);
    running = 0;
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
